// File: rtl/nibble_serial_csla_adder.sv
// nibble_serial_csla_adder
//   Sequential WIDTH-bit adder. Operands are accepted with a valid/ready
//   handshake, then consumed one nibble per clock through a single 4-bit
//   carry-select slice. The result is presented with a second valid/ready
//   handshake.
//
//   Ports:
//     clk, rst            clock (rising edge), asynchronous active-high reset
//     start_valid/ready   operand handshake (ready only while IDLE)
//     a, b, cin           operands and carry into bit 0
//     done_valid/ready    result handshake
//     sum_out, cout       registered sum and carry out of bit WIDTH-1
//     ovf                 signed overflow flag (only with CSLA_OVF_FLAG_EN)
//
//   Optional feature macro: CSLA_OVF_FLAG_EN adds the ovf output.

// 4-bit carry-select slice: both carry hypotheses are summed in parallel
// and the real carry-in only drives the final select.
module csla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [4:0] s
);
    logic [4:0] s0;
    logic [4:0] s1;

    always_comb begin
        s0 = {1'b0, a} + {1'b0, b};
        s1 = {1'b0, a} + {1'b0, b} + 5'd1;
        s  = ci ? s1 : s0;
    end
endmodule

module nibble_serial_csla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum_out,
`ifdef CSLA_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_csla_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  partial_q, partial_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              done_valid_q, done_valid_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [4:0]        nib;

    csla_slice4 u_slice (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (carry_q),
        .s  (nib)
    );

`ifdef CSLA_OVF_FLAG_EN
    logic ovf_q, ovf_d;
    // Carry into the top bit is recovered from the top-bit sum: c3 = a3^b3^s3.
    logic c_into_msb;
    assign c_into_msb = a_sh_q[3] ^ b_sh_q[3] ^ nib[3];
`endif

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        partial_d    = partial_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        done_valid_d = done_valid_q;
        idx_d        = idx_q;
`ifdef CSLA_OVF_FLAG_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                partial_d[{idx_q, 2'b00} +: 4] = nib[3:0];
                carry_d = nib[4];
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    // Publish including the nibble written this cycle.
                    sum_d        = partial_d;
                    cout_d       = nib[4];
                    done_valid_d = 1'b1;
`ifdef CSLA_OVF_FLAG_EN
                    ovf_d        = c_into_msb ^ nib[4];
`endif
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            partial_q    <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            done_valid_q <= 1'b0;
            idx_q        <= '0;
`ifdef CSLA_OVF_FLAG_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            partial_q    <= partial_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            cout_q       <= cout_d;
            done_valid_q <= done_valid_d;
            idx_q        <= idx_d;
`ifdef CSLA_OVF_FLAG_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign done_valid  = done_valid_q;
    assign sum_out     = sum_q;
    assign cout        = cout_q;
`ifdef CSLA_OVF_FLAG_EN
    assign ovf         = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_csla_adder.sv
module tb_nibble_serial_csla_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         done_valid;
    logic         done_ready = 1'b0;
    logic [W-1:0] sum_out;
    logic         cout;
`ifdef CSLA_OVF_FLAG_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    // {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    nibble_serial_csla_adder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum_out     (sum_out),
`ifdef CSLA_OVF_FLAG_EN
        .ovf         (ovf),
`endif
        .cout        (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        logic       o;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        o    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {o, full};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand set and let it be accepted on the next edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        start_valid = 1'b1;
        a = x; b = y; cin = c;
        exp_q.push_back(model(x, y, c));
        tick();
        start_valid = 1'b0;
    endtask

    // Edges elapsed after accept until done_valid is seen (99 on timeout).
    task automatic wait_done(output int n);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done_valid) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        total++;
        if (start_ready !== 1'b1 || done_valid !== 1'b0 || sum_out !== '0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset: rdy=%b dv=%b sum=%h cout=%b want 1 0 0000 0", start_ready, done_valid, sum_out, cout);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [W+1:0] e;
        issue(16'h1234, 16'h4321, 1'b0);
        wait_done(n);
        total++;
        if (n !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", n); end
        e = exp_q.pop_front();
        total++;
        if ({cout, sum_out} !== e[W:0]) begin bad++; $display("FAIL basic_sum: got %b_%h want %b_%h", cout, sum_out, e[W], e[W-1:0]); end
        done_ready = 1'b1; tick(); done_ready = 1'b0;
        total++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1) begin bad++; $display("FAIL basic_release: dv=%b rdy=%b want 0 1", done_valid, start_ready); end
    endtask

    task automatic test_full_ripple();
        int n;
        logic [W+1:0] e;
        logic [W-1:0] xs[2] = '{16'hFFFF, 16'hFFFF};
        logic [W-1:0] ys[2] = '{16'h0001, 16'h0000};
        logic         cs[2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            issue(xs[k], ys[k], cs[k]);
            wait_done(n);
            e = exp_q.pop_front();
            total++;
            if (n !== 4 || {cout, sum_out} !== e[W:0]) begin
                bad++;
                $display("FAIL ripple%0d: lat=%0d got %b_%h want 4 %b_%h", k, n, cout, sum_out, e[W], e[W-1:0]);
            end
            done_ready = 1'b1; tick(); done_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [W+1:0] e;
        issue(16'hABCD, 16'h1111, 1'b1);
        wait_done(n);
        e = exp_q.pop_front();
        start_valid = 1'b1; a = 16'h0F0F; b = 16'h7070; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (start_ready !== 1'b0 || done_valid !== 1'b1 || {cout, sum_out} !== e[W:0]) begin
                bad++;
                $display("FAIL bp_hold%0d: rdy=%b dv=%b got %b_%h want 0 1 %b_%h", i, start_ready, done_valid, cout, sum_out, e[W], e[W-1:0]);
            end
        end
        done_ready = 1'b1; tick(); done_ready = 1'b0;
        total++;
        if (start_ready !== 1'b1 || done_valid !== 1'b0) begin bad++; $display("FAIL bp_idle: rdy=%b dv=%b want 1 0", start_ready, done_valid); end
        exp_q.push_back(model(a, b, cin));
        tick(); start_valid = 1'b0;
        total++;
        if (start_ready !== 1'b0) begin bad++; $display("FAIL bp_accept: rdy=%b want 0", start_ready); end
        wait_done(n);
        e = exp_q.pop_front();
        total++;
        if (n !== 4 || {cout, sum_out} !== e[W:0]) begin bad++; $display("FAIL bp_result: lat=%0d got %b_%h want 4 %b_%h", n, cout, sum_out, e[W], e[W-1:0]); end
        done_ready = 1'b1; tick(); done_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [W+1:0] e;
        issue(16'h8888, 16'h8888, 1'b0);
        tick(); tick();
        rst = 1'b1;
        #1;
        total++;
        if (done_valid !== 1'b0 || sum_out !== '0 || cout !== 1'b0 || start_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: dv=%b sum=%h cout=%b rdy=%b want 0 0000 0 1", done_valid, sum_out, cout, start_ready);
        end
        exp_q.delete();
        tick();
        rst = 1'b0;
        issue(16'h00FF, 16'h0F01, 1'b0);
        wait_done(n);
        e = exp_q.pop_front();
        total++;
        if (n !== 4 || {cout, sum_out} !== {1'b0, 16'h1000} || e[W:0] !== {1'b0, 16'h1000}) begin
            bad++;
            $display("FAIL reset_after: lat=%0d got %b_%h want 4 0_1000", n, cout, sum_out);
        end
        done_ready = 1'b1; tick(); done_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xs[3] = '{16'h1111, 16'hFFFE, 16'h8000};
        logic [W-1:0] ys[3] = '{16'h2222, 16'h0001, 16'h8000};
        logic         cs[3] = '{1'b1, 1'b1, 1'b0};
        logic [W+1:0] e;
        int issued = 0, got = 0, last_cyc = -1;
        done_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
            if (done_valid) begin
                e = exp_q.pop_front();
                total++;
                if ({cout, sum_out} !== e[W:0]) begin bad++; $display("FAIL b2b_result%0d: got %b_%h want %b_%h", got, cout, sum_out, e[W], e[W-1:0]); end
                if (last_cyc >= 0) begin
                    total++;
                    if (cyc - last_cyc !== 6) begin bad++; $display("FAIL b2b_spacing%0d: got %0d want 6", got, cyc - last_cyc); end
                end
                last_cyc = cyc;
                got++;
            end
            if (start_ready) begin
                if (issued < 3) begin
                    start_valid = 1'b1;
                    a = xs[issued]; b = ys[issued]; cin = cs[issued];
                    exp_q.push_back(model(a, b, cin));
                    issued++;
                end else begin
                    start_valid = 1'b0;
                end
            end
            tick();
        end
        start_valid = 1'b0;
        total++;
        if (got !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", got); end
        tick();
        done_ready = 1'b0;
        exp_q.delete();
    endtask

`ifdef CSLA_OVF_FLAG_EN
    task automatic test_ovf();
        int n;
        logic [W-1:0] xs[2] = '{16'h7FFF, 16'hFFFF};
        logic         wo[2] = '{1'b1, 1'b0};
        logic         wc[2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            issue(xs[k], 16'h0001, 1'b0);
            wait_done(n);
            void'(exp_q.pop_front());
            total++;
            if (ovf !== wo[k] || cout !== wc[k]) begin bad++; $display("FAIL ovf%0d: ovf=%b cout=%b want %b %b", k, ovf, cout, wo[k], wc[k]); end
            done_ready = 1'b1; tick(); done_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_full_ripple();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef CSLA_OVF_FLAG_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
